// File: rtl/ifetch_port_if.sv
// Instruction bus between the fetch initiator and the I-cache/ibus.
// The master (the fetch port) drives the address request; the slave accepts
// the address and returns one data beat per accepted request.
interface ifetch_port_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              ireq_addr_ok;
  logic              idata_ok;
  logic [INST_W-1:0] idata;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  ireq_addr_ok,
    input  idata_ok,
    input  idata
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output ireq_addr_ok,
    output idata_ok,
    output idata
  );
endinterface

// File: rtl/ifetch_port.sv
// Instruction fetch port: issues one bus fetch per F-stage PC, forwards the
// returned instruction to F2, raises i_wait for the hazard unit, and discards
// responses that belong to a fetch flushed while still in flight.
// Optional feature macro IFETCH_PERF_EN adds perf_wait_cyc / perf_drop_cnt.
module ifetch_port #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stallF,
  input  logic              flushF,
  ifetch_port_if.master     bus,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              if_misalign,
  output logic              i_wait
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_wait_cyc,
  output logic [31:0]       perf_drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HOLD} state_t;

  state_t            state, nextState;
  logic [ADDR_W-1:0] pcQ;
  logic [INST_W-1:0] instQ;
  logic              loadPc, loadInst, dropEvt;
  logic              reqValid;
  logic [ADDR_W-1:0] reqAddr;

  // State and captured fetch context
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pcQ   <= '0;
      instQ <= '0;
    end else begin
      state <= nextState;
      if (loadPc)   pcQ   <= pc;
      if (loadInst) instQ <= bus.idata;
    end
  end

  // Next state and all outputs; everything is forced low while reset is high
  always_comb begin
    nextState   = state;
    reqValid    = 1'b0;
    reqAddr     = '0;
    inst_valid  = 1'b0;
    inst        = '0;
    inst_pc     = '0;
    if_misalign = 1'b0;
    i_wait      = 1'b0;
    loadPc      = 1'b0;
    loadInst    = 1'b0;
    dropEvt     = 1'b0;
    case (state)
      IDLE: begin
        if (pc_valid && !flushF) begin
          if (pc[1:0] == 2'b00) begin
            reqValid = 1'b1;
            reqAddr  = pc;
            i_wait   = 1'b1;
            if (bus.ireq_addr_ok) begin
              loadPc    = 1'b1;
              nextState = WAIT;
            end
          end else begin
            // Misaligned PC is reported straight to F2 without a bus access
            inst_valid  = 1'b1;
            if_misalign = 1'b1;
            inst_pc     = pc;
          end
        end
      end
      WAIT: begin
        if (bus.idata_ok) begin
          if (!flushF) begin
            inst_valid = 1'b1;
            inst       = bus.idata;
            inst_pc    = pcQ;
            if (stallF) begin
              loadInst  = 1'b1;
              nextState = HOLD;
            end else begin
              nextState = IDLE;
            end
          end else begin
            dropEvt   = 1'b1;
            nextState = IDLE;
          end
        end else begin
          i_wait = 1'b1;
          if (flushF) nextState = DROP;
        end
      end
      DROP: begin
        i_wait = 1'b1;
        if (bus.idata_ok) begin
          dropEvt   = 1'b1;
          nextState = IDLE;
        end
      end
      HOLD: begin
        if (flushF) begin
          nextState = IDLE;
        end else begin
          inst_valid = 1'b1;
          inst       = instQ;
          inst_pc    = pcQ;
          if (!stallF) nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    if (reset) begin
      reqValid    = 1'b0;
      reqAddr     = '0;
      inst_valid  = 1'b0;
      inst        = '0;
      inst_pc     = '0;
      if_misalign = 1'b0;
      i_wait      = 1'b0;
    end
  end

  assign bus.ireq_valid = reqValid;
  assign bus.ireq_addr  = reqAddr;

`ifdef IFETCH_PERF_EN
  // Free-running stall and discard counters, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_wait_cyc <= '0;
      perf_drop_cnt <= '0;
    end else begin
      if (i_wait)  perf_wait_cyc <= perf_wait_cyc + 32'd1;
      if (dropEvt) perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

  // A data beat is only legal while a request is outstanding
  a_noStrayResp: assert property (@(posedge clk) disable iff (reset)
    !(bus.idata_ok && (state == IDLE || state == HOLD)));

endmodule

// File: tb/tb_ifetch_port.sv
// Directed bench for ifetch_port with hand-computed expectations.
module tb_ifetch_port;
  localparam int ADDR_W = 64;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              pc_valid;
  logic [ADDR_W-1:0] pc;
  logic              stallF;
  logic              flushF;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              if_misalign;
  logic              i_wait;
`ifdef IFETCH_PERF_EN
  logic [31:0]       perf_wait_cyc;
  logic [31:0]       perf_drop_cnt;
`endif

  int nChk = 0;
  int nBad = 0;

  ifetch_port_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  ifetch_port #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_valid    (pc_valid),
    .pc          (pc),
    .stallF      (stallF),
    .flushF      (flushF),
    .bus         (bus.master),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .if_misalign (if_misalign),
    .i_wait      (i_wait)
`ifdef IFETCH_PERF_EN
    ,
    .perf_wait_cyc (perf_wait_cyc),
    .perf_drop_cnt (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle, apply inputs just after the edge, let them settle
  task automatic step(input logic pv, input logic [63:0] p, input logic aok,
                      input logic dok, input logic [31:0] d, input logic stl,
                      input logic fl);
    @(posedge clk);
    #1;
    pc_valid         = pv;
    pc               = p;
    bus.ireq_addr_ok = aok;
    bus.idata_ok     = dok;
    bus.idata        = d;
    stallF           = stl;
    flushF           = fl;
    #1;
  endtask

  // Compact output check: request, wait, valid, inst, inst_pc
  task automatic expOut(input string tag, input logic rv, input logic w,
                        input logic v, input logic [31:0] i, input logic [63:0] ipc);
    chk({tag, ".ireq_valid"}, {63'd0, bus.ireq_valid}, {63'd0, rv});
    chk({tag, ".i_wait"},     {63'd0, i_wait},         {63'd0, w});
    chk({tag, ".inst_valid"}, {63'd0, inst_valid},     {63'd0, v});
    if (v) begin
      chk({tag, ".inst"},    {32'd0, inst}, {32'd0, i});
      chk({tag, ".inst_pc"}, inst_pc,       ipc);
    end
  endtask

  initial begin
    reset = 1'b1;
    pc_valid = 1'b1; pc = 64'h8000_0000; stallF = 1'b0; flushF = 1'b0;
    bus.ireq_addr_ok = 1'b1; bus.idata_ok = 1'b0; bus.idata = '0;
    #2;
    // Reset: every output held low even with a valid PC presented
    expOut("rst", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("rst.if_misalign", {63'd0, if_misalign}, 64'd0);
    chk("rst.ireq_addr", bus.ireq_addr, 64'h0);
`ifdef IFETCH_PERF_EN
    chk("rst.perf_drop", {32'd0, perf_drop_cnt}, 64'd0);
    chk("rst.perf_wait", {32'd0, perf_wait_cyc}, 64'd0);
`endif

    // Basic fetch: accept on cycle 0, data on cycle 3
    step(1'b1, 64'h8000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    expOut("f0.c0", 1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
    chk("f0.addr", bus.ireq_addr, 64'h8000_0000);
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("f0.c1", 1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    step(1'b1, 64'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("f0.c2", 1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    step(1'b1, 64'h8000_0000, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
    expOut("f0.c3", 1'b0, 1'b0, 1'b1, 32'h0000_0013, 64'h8000_0000);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("f0.idle", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

    // Address not accepted for 4 cycles; the PC changes while retrying
    for (int k = 0; k < 4; k++) begin
      step(1'b1, (k < 2) ? 64'h1000 : 64'h1004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      expOut($sformatf("retry%0d", k), 1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
    end
    step(1'b1, 64'h1004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("retry.acc", 1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
    chk("retry.addr", bus.ireq_addr, 64'h1004);
    step(1'b1, 64'h1008, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("retry.one", 1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0);
    expOut("retry.data", 1'b0, 1'b0, 1'b1, 32'h0010_0093, 64'h1004);

    // Flush in WAIT, response arrives two cycles later and is discarded
    step(1'b1, 64'h2000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("drop.req", 1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    expOut("drop.flush", 1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    expOut("drop.absorb", 1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    expOut("drop.resp", 1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("drop.idle", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
`ifdef IFETCH_PERF_EN
    chk("drop.perf", {32'd0, perf_drop_cnt}, 64'd1);
`endif

    // Flush coinciding with the response: dropped, no wait
    step(1'b1, 64'h2004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1);
    expOut("dropNow", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("dropNow.idle", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
`ifdef IFETCH_PERF_EN
    chk("dropNow.perf", {32'd0, perf_drop_cnt}, 64'd2);
`endif

    // Data with stallF high for 3 cycles, then released
    step(1'b1, 64'h3000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 32'h0050_0513, 1'b1, 1'b0);
    expOut("hold.c0", 1'b0, 1'b0, 1'b1, 32'h0050_0513, 64'h3000);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    expOut("hold.c1", 1'b0, 1'b0, 1'b1, 32'h0050_0513, 64'h3000);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    expOut("hold.c2", 1'b0, 1'b0, 1'b1, 32'h0050_0513, 64'h3000);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("hold.rel", 1'b0, 1'b0, 1'b1, 32'h0050_0513, 64'h3000);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("hold.idle", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

    // Flush while holding kills the held instruction
    step(1'b1, 64'h3004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 32'h0000_0073, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    expOut("holdFl", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    expOut("holdFl.idle", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

    // Misaligned PC: reported immediately, no request
    step(1'b1, 64'h8000_0002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("mis", 1'b0, 1'b0, 1'b1, 32'h0, 64'h8000_0002);
    chk("mis.flag", {63'd0, if_misalign}, 64'd1);
    // Flush in IDLE suppresses both request and misalign report
    step(1'b1, 64'h8000_0002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    expOut("misFl", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("misFl.flag", {63'd0, if_misalign}, 64'd0);
    step(1'b1, 64'h4000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    expOut("idleFl", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

    // Reset during WAIT: outputs clear at once, new request after release
    step(1'b1, 64'h4000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("rw.req", 1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
    step(1'b1, 64'h4000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("rw.wait", 1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    reset = 1'b1;
    #1;
    expOut("rw.rst", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    step(1'b1, 64'h5000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("rw.rstHi", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    reset = 1'b0;
    #1;
    expOut("rw.new", 1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
    chk("rw.addr", bus.ireq_addr, 64'h5000);
    step(1'b0, 64'h0, 1'b0, 1'b1, 32'h0000_0007, 1'b0, 1'b0);
    expOut("rw.data", 1'b0, 1'b0, 1'b1, 32'h0000_0007, 64'h5000);
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    expOut("rw.idle", 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end
endmodule
